// File: rtl/shift_req_arbiter.sv
// Purpose: round-robin share of one external barrel shifter between two FPU requesters, tagged responses.
// Latency: 2 cycles accept-to-response (issue register, then result register); 1 op/cycle sustained.
// Backpressure: rsp_ready=0 stalls the result register, then stage 1; readies drop once both stages are full.
module shift_req_arbiter #(
    parameter int W  = 16,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_a,
    input  logic [SW-1:0] req0_s,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_a,
    input  logic [SW-1:0] req1_s,
    output logic [W-1:0]  sh_a,
    output logic [SW-1:0] sh_s,
    input  logic [W-1:0]  sh_y,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_y,
    output logic          rsp_id,
    output logic          busy
);

    // Issue stage holding the operation currently presented to the shifter
    logic          s1_v;
    logic [W-1:0]  s1_a;
    logic [SW-1:0] s1_s;
    logic          s1_id;

    // Last requester granted; 1 means req0 has priority on the next contest
    logic          lrg;

    logic          s2_load;
    logic          s1_free;
    logic          g0;
    logic          g1;
    logic          accept;

    // Stage 2 takes stage 1 whenever the result slot is empty or being drained
    assign s2_load = s1_v & (~rsp_valid | rsp_ready);
    assign s1_free = ~s1_v | s2_load;

    // Round-robin grant; g0 and g1 are mutually exclusive
    assign g0     = req0_valid & (~req1_valid | lrg);
    assign g1     = req1_valid & (~req0_valid | ~lrg);
    assign accept = s1_free & (g0 | g1);

    // Readies are independent of the requester's own valid; held low while in reset
    assign req0_ready = rst_n & s1_free & (~req1_valid | lrg);
    assign req1_ready = rst_n & s1_free & (~req0_valid | ~lrg);

    // Shifter inputs come only from registers, so no req-to-shifter combinational path exists
    assign sh_a = s1_a;
    assign sh_s = s1_s;

    assign busy = s1_v | rsp_valid;

    // Issue register: load the granted operation, or empty out when drained with no refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_s  <= '0;
            s1_id <= 1'b0;
            lrg   <= 1'b1;
        end else if (accept) begin
            s1_v  <= 1'b1;
            s1_a  <= g1 ? req1_a : req0_a;
            s1_s  <= g1 ? req1_s : req0_s;
            s1_id <= g1;
            lrg   <= g1;
        end else if (s2_load) begin
            s1_v  <= 1'b0;
        end
    end

    // Result register: capture shifter output with its tag, hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= 1'b0;
        end else if (s2_load) begin
            rsp_valid <= 1'b1;
            rsp_y     <= sh_y;
            rsp_id    <= s1_id;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Purpose: directed test of shift_req_arbiter with a queued scoreboard and an independent response monitor.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: rsp_ready is driven per test vector to exercise stalls.
module tb_shift_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [3:0]  req0_s;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [3:0]  req1_s;
    logic [15:0] sh_a;
    logic [3:0]  sh_s;
    logic [15:0] sh_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_y;
    logic        rsp_id;
    logic        busy;

    typedef struct packed {
        logic        id;
        logic [15:0] y;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // External shared shifter: logical right shift, zero fill
    assign sh_y = sh_a >> sh_s;

    shift_req_arbiter #(.W(16), .SW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_s     (req0_s),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_s     (req1_s),
        .sh_a       (sh_a),
        .sh_s       (sh_s),
        .sh_y       (sh_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_y      (rsp_y),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response transfer must match the head of the expected queue
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id=%0d y=%h expected no response", rsp_id, rsp_y);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_id", 16'(rsp_id), 16'(e.id));
                check("rsp_y", rsp_y, e.y);
            end
        end
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both requesters active
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a     = 16'hFFFF;
        req0_s     = 4'd4;
        req1_a     = 16'h8000;
        req1_s     = 4'd15;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        check("rst_rsp_y", rsp_y, 16'h0);
        check("rst_rsp_id", 16'(rsp_id), 16'h0);
        check("rst_sh_a", sh_a, 16'h0);
        check("rst_sh_s", 16'(sh_s), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_req0_ready", 16'(req0_ready), 16'h0);
        check("rst_req1_ready", 16'(req1_ready), 16'h0);

        // Contention: release reset with both valid; req0 first, then strict alternation
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{id: 1'b0, y: 16'h0FFF});
            exp_q.push_back('{id: 1'b1, y: 16'h0001});
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k == 6) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
            check("ctn_rsp_valid", 16'(rsp_valid), 16'(k >= 2 && k <= 7));
            if (k < 6) begin
                check("ctn_req0_ready", 16'(req0_ready), 16'(k % 2 == 0));
                check("ctn_req1_ready", 16'(req1_ready), 16'(k % 2 == 1));
            end
            tick();
        end
        @(negedge clk);
        check("ctn_busy_idle", 16'(busy), 16'h0);
        tick();

        // Single request, two-cycle latency
        exp_q.push_back('{id: 1'b0, y: 16'h0004});
        req0_a = 16'h0010;
        req0_s = 4'd2;
        for (int k = 0; k < 4; k++) begin
            req0_valid = (k == 0);
            @(negedge clk);
            if (k == 0) check("one_req0_ready", 16'(req0_ready), 16'h1);
            check("one_rsp_valid", 16'(rsp_valid), 16'(k == 2));
            check("one_busy", 16'(busy), 16'(k >= 1 && k <= 2));
            tick();
        end

        // Backpressure: req1 streams 0x1234 with s=0,1,2 while rsp_ready is low for 5 cycles
        exp_q.push_back('{id: 1'b1, y: 16'h1234});
        exp_q.push_back('{id: 1'b1, y: 16'h091A});
        exp_q.push_back('{id: 1'b1, y: 16'h048D});
        req1_a = 16'h1234;
        for (int k = 0; k < 9; k++) begin
            req1_valid = (k < 6);
            if (k == 0)      req1_s = 4'd0;
            else if (k == 1) req1_s = 4'd1;
            else             req1_s = 4'd2;
            rsp_ready = (k >= 5);
            @(negedge clk);
            if (k < 2) check("bp_req1_ready_open", 16'(req1_ready), 16'h1);
            if (k >= 2 && k <= 4) begin
                check("bp_req1_ready_held", 16'(req1_ready), 16'h0);
                check("bp_rsp_valid", 16'(rsp_valid), 16'h1);
                check("bp_rsp_y_stable", rsp_y, 16'h1234);
                check("bp_rsp_id_stable", 16'(rsp_id), 16'h1);
            end
            if (k == 3) check("bp_s1_second_op", 16'(sh_s), 16'h1);
            check("bp_busy", 16'(busy), 16'(k >= 1 && k <= 7));
            tick();
        end

        // Drain and refill in the same cycle: req0, req1, req0 back to back
        rsp_ready = 1'b1;
        exp_q.push_back('{id: 1'b0, y: 16'h000F});
        exp_q.push_back('{id: 1'b1, y: 16'h00A5});
        exp_q.push_back('{id: 1'b0, y: 16'h0001});
        req1_a = 16'hA5A5;
        req1_s = 4'd8;
        for (int k = 0; k < 6; k++) begin
            req0_valid = (k == 0 || k == 2);
            req1_valid = (k == 1);
            req0_a     = (k == 0) ? 16'h00F0 : 16'h8001;
            req0_s     = (k == 0) ? 4'd4 : 4'd15;
            @(negedge clk);
            if (k == 2) begin
                check("dr_rsp_valid", 16'(rsp_valid), 16'h1);
                check("dr_s1_holds_b", sh_a, 16'hA5A5);
                check("dr_req0_ready", 16'(req0_ready), 16'h1);
            end
            if (k == 3) check("dr_s1_refilled", sh_a, 16'h8001);
            check("dr_busy", 16'(busy), 16'(k >= 1 && k <= 4));
            tick();
        end

        // Mid-operation reset with two ops in flight: both discarded
        rsp_ready = 1'b0;
        req0_a    = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            req0_valid = (k < 2);
            req0_s     = (k == 0) ? 4'd1 : 4'd2;
            @(negedge clk);
            if (k == 2) begin
                check("mr_rsp_valid_pre", 16'(rsp_valid), 16'h1);
                check("mr_s1_full_pre", sh_s, 16'h2);
            end
            if (k < 2) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rsp_valid_async", 16'(rsp_valid), 16'h0);
        check("mr_busy_async", 16'(busy), 16'h0);
        check("mr_sh_a_async", sh_a, 16'h0);
        tick();
        tick();
        rst_n      = 1'b1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("mr_req0_ready_first", 16'(req0_ready), 16'h1);
        check("mr_req1_ready_first", 16'(req1_ready), 16'h0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mr_no_stale_rsp", 16'(rsp_valid), 16'h0);
        end
        check("scoreboard_empty", 16'(exp_q.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
